// File: rtl/wb_pkg.sv
// Shared Wishbone field widths for the data bus and its per-slave pipeline slices.
package wb_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_ADDR_WIDTH = 32;

    function automatic int unsigned wb_sel_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone pipelined bus bundle; master drives the request, slave drives the response.
interface wb_if
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = WB_ADDR_WIDTH,
    parameter int unsigned SELECT_WIDTH = wb_sel_width(DATA_WIDTH)
);

    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_m;
    logic [DATA_WIDTH-1:0]   dat_s;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    we;
    logic                    cyc;
    logic                    stb;
    logic                    ack;
    logic                    err;
    logic                    stall;

    modport master (
        output adr, dat_m, sel, we, cyc, stb,
        input  dat_s, ack, err, stall
    );

    modport slave (
        input  adr, dat_m, sel, we, cyc, stb,
        output dat_s, ack, err, stall
    );

endinterface

// File: rtl/wb_slave_reg_slice.sv
// Registered Wishbone stage between a data bus mux slave port and one peripheral.
// One transaction in flight; request and response paths are both fully registered.
module wb_slave_reg_slice
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = WB_ADDR_WIDTH,
    parameter int unsigned SELECT_WIDTH = wb_sel_width(DATA_WIDTH)
) (
    input logic  clk,
    input logic  rst_n,
    wb_if.slave  wbm,
    wb_if.master wbs
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_e;

    state_e                  state_q;
    logic                    wbs_cyc_q;
    logic                    wbs_stb_q;
    logic                    wbm_stall_q;

    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_m_q;
    logic [SELECT_WIDTH-1:0] sel_q;
    logic                    we_q;

    logic [DATA_WIDTH-1:0]   dat_s_q;
    logic                    ack_q;
    logic                    err_q;

    logic                    req_load;
    logic                    slave_done;
    logic                    rsp_load;

    // Responses are only taken while the upstream cycle is alive, so an abort discards them.
    always_comb begin
        req_load   = 1'b0;
        slave_done = wbs.ack | wbs.err;
        rsp_load   = 1'b0;
        case (state_q)
            IDLE:    req_load = wbm.cyc & wbm.stb;
            REQ:     rsp_load = wbm.cyc & ~wbs.stall & slave_done;
            WAIT:    rsp_load = wbm.cyc & slave_done;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wbs_cyc_q   <= 1'b0;
            wbs_stb_q   <= 1'b0;
            wbm_stall_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_load) begin
                        wbs_cyc_q   <= 1'b1;
                        wbs_stb_q   <= 1'b1;
                        wbm_stall_q <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (!wbm.cyc) begin
                        wbs_cyc_q   <= 1'b0;
                        wbs_stb_q   <= 1'b0;
                        wbm_stall_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (!wbs.stall) begin
                        wbs_stb_q <= 1'b0;
                        if (slave_done) begin
                            wbs_cyc_q <= 1'b0;
                            state_q   <= RESP;
                        end else begin
                            state_q   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!wbm.cyc) begin
                        wbs_cyc_q   <= 1'b0;
                        wbm_stall_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (slave_done) begin
                        wbs_cyc_q <= 1'b0;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    wbm_stall_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    wbs_cyc_q   <= 1'b0;
                    wbs_stb_q   <= 1'b0;
                    wbm_stall_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q   <= '0;
            dat_m_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
        end else if (req_load) begin
            adr_q   <= wbm.adr;
            dat_m_q <= wbm.dat_m;
            sel_q   <= wbm.sel;
            we_q    <= wbm.we;
        end
    end

    // ack/err self-clear to give a single-cycle pulse; err takes priority over ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_s_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (rsp_load) begin
                dat_s_q <= wbs.dat_s;
                ack_q   <= wbs.ack & ~wbs.err;
                err_q   <= wbs.err;
            end
        end
    end

    assign wbs.adr   = adr_q;
    assign wbs.dat_m = dat_m_q;
    assign wbs.sel   = sel_q;
    assign wbs.we    = we_q;
    assign wbs.cyc   = wbs_cyc_q;
    assign wbs.stb   = wbs_stb_q;

    assign wbm.dat_s = dat_s_q;
    assign wbm.ack   = ack_q;
    assign wbm.err   = err_q;
    assign wbm.stall = wbm_stall_q;

endmodule

// File: tb/tb_wb_slave_reg_slice.sv
// Bench for wb_slave_reg_slice: scripted and random transactions against a configurable slave model.
module tb_wb_slave_reg_slice;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) wbm_if ();
    wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) wbs_if ();

    wb_slave_reg_slice #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wbm  (wbm_if),
        .wbs  (wbs_if)
    );

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Slave model: stalls cfg_stall cycles, answers cfg_delay cycles after accept (0 = same cycle).
    // cfg_kind: 0 ack, 1 err, 2 ack and err together.
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } req_t;
    req_t seen_q[$];

    int unsigned cfg_stall = 0;
    int unsigned cfg_delay = 1;
    int unsigned cfg_kind = 0;
    logic [31:0] cfg_data = '0;
    int unsigned stb_seen = 0;
    int unsigned timer = 0;
    logic        s_ack_q = 1'b0;
    logic        s_err_q = 1'b0;
    logic [31:0] s_dat_q = '0;
    logic        s_accept;
    logic        s_comb;

    assign wbs_if.stall = wbs_if.cyc && wbs_if.stb && (stb_seen < cfg_stall);
    assign s_accept     = wbs_if.cyc && wbs_if.stb && !wbs_if.stall;
    assign s_comb       = s_accept && (cfg_delay == 0);
    assign wbs_if.ack   = s_ack_q | (s_comb && cfg_kind != 1);
    assign wbs_if.err   = s_err_q | (s_comb && cfg_kind != 0);
    assign wbs_if.dat_s = s_comb ? cfg_data : s_dat_q;

    always @(posedge clk) begin
        stb_seen <= (wbs_if.cyc && wbs_if.stb) ? stb_seen + 1 : 0;
        s_ack_q  <= 1'b0;
        s_err_q  <= 1'b0;
        if (s_accept) begin
            seen_q.push_back('{adr: wbs_if.adr, dat: wbs_if.dat_m, sel: wbs_if.sel, we: wbs_if.we});
        end
        if (s_accept && cfg_delay == 1) begin
            s_ack_q <= (cfg_kind != 1);
            s_err_q <= (cfg_kind != 0);
            s_dat_q <= cfg_data;
        end else if (s_accept && cfg_delay > 1) begin
            timer <= cfg_delay - 1;
        end else if (timer == 1) begin
            s_ack_q <= (cfg_kind != 1);
            s_err_q <= (cfg_kind != 0);
            s_dat_q <= cfg_data;
            timer   <= 0;
        end else if (timer > 1) begin
            timer <= timer - 1;
        end
    end

    // Presents a request at a negedge and returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w, output int unsigned waited, output logic ok);
        wbm_if.cyc   = 1'b1;
        wbm_if.stb   = 1'b1;
        wbm_if.adr   = a;
        wbm_if.dat_m = d;
        wbm_if.sel   = s;
        wbm_if.we    = w;
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < 40) begin
            if (wbm_if.stall === 1'b0) begin
                ok = 1'b1;
                n_cmp++;
                if ({wbm_if.ack, wbm_if.err} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL idle_quiet: ack/err=%b while accepting, want 00", {wbm_if.ack, wbm_if.err});
                end
            end else begin
                waited++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        wbm_if.stb = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            wbm_if.cyc = 1'b0;
            $display("FAIL accept_timeout: stalled %0d cycles, want accept", waited);
        end
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, input int unsigned st, input int unsigned dl,
                           input int unsigned kind, input logic [31:0] rdat,
                           output int unsigned waited, output int unsigned ack_at);
        logic ok, bad, stall_bad;
        int unsigned n, stb_n;
        req_t r;
        cfg_stall = st;
        cfg_delay = dl;
        cfg_kind  = kind;
        cfg_data  = rdat;
        ack_at = 0;
        issue(a, d, s, w, waited, ok);
        if (!ok) return;
        n_cmp++;
        if ({wbs_if.cyc, wbs_if.stb, wbs_if.adr, wbs_if.dat_m, wbs_if.sel, wbs_if.we} !==
            {1'b1, 1'b1, a, d, s, w}) begin
            n_fail++;
            $display("FAIL req_fields: cyc=%b stb=%b adr=%h dat=%h sel=%h we=%b, want 1 1 %h %h %h %b",
                     wbs_if.cyc, wbs_if.stb, wbs_if.adr, wbs_if.dat_m, wbs_if.sel, wbs_if.we, a, d, s, w);
        end
        n_cmp++;
        if ({wbm_if.ack, wbm_if.err} !== 2'b00) begin
            n_fail++;
            $display("FAIL early_resp: ack/err=%b right after accept, want 00", {wbm_if.ack, wbm_if.err});
        end
        n = 1;
        stb_n = 0;
        bad = 1'b0;
        stall_bad = 1'b0;
        while (!(wbm_if.ack === 1'b1 || wbm_if.err === 1'b1) && n < 60) begin
            if (wbs_if.stb === 1'b1) begin
                stb_n++;
                if ({wbs_if.adr, wbs_if.dat_m, wbs_if.sel, wbs_if.we} !== {a, d, s, w}) bad = 1'b1;
            end
            if (wbm_if.stall !== 1'b1) stall_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        ack_at = cyc_cnt;
        n_cmp++;
        if (n != 2 + st + dl) begin
            n_fail++;
            $display("FAIL latency: accept-to-response %0d cycles, want %0d", n, 2 + st + dl);
        end
        n_cmp++;
        if (stb_n != st + 1 || bad) begin
            n_fail++;
            $display("FAIL stb_hold: stb cycles %0d unstable=%b, want %0d stable", stb_n, bad, st + 1);
        end
        n_cmp++;
        if (stall_bad) begin
            n_fail++;
            $display("FAIL busy_stall: stall dropped while busy, want 1 throughout");
        end
        n_cmp++;
        if ({wbm_if.ack, wbm_if.err} !== {kind == 0, kind != 0}) begin
            n_fail++;
            $display("FAIL resp_kind: ack/err=%b, want %b", {wbm_if.ack, wbm_if.err}, {kind == 0, kind != 0});
        end
        if (kind == 0) begin
            n_cmp++;
            if (wbm_if.dat_s !== rdat) begin
                n_fail++;
                $display("FAIL rdata: dat_s=%h, want %h", wbm_if.dat_s, rdat);
            end
        end
        n_cmp++;
        if (seen_q.size() != 1) begin
            n_fail++;
            $display("FAIL slave_count: slave saw %0d requests, want 1", seen_q.size());
            seen_q.delete();
        end else begin
            r = seen_q.pop_front();
            if ({r.adr, r.dat, r.sel, r.we} !== {a, d, s, w}) begin
                n_fail++;
                $display("FAIL slave_req: adr=%h dat=%h sel=%h we=%b, want %h %h %h %b",
                         r.adr, r.dat, r.sel, r.we, a, d, s, w);
            end
        end
    endtask

    task automatic finish_txn();
        wbm_if.cyc = 1'b0;
        wbm_if.stb = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wbm_if.ack, wbm_if.err, wbm_if.stall, wbs_if.cyc} !== 4'b0000) begin
            n_fail++;
            $display("FAIL pulse_end: ack/err/stall/wbs_cyc=%b, want 0000",
                     {wbm_if.ack, wbm_if.err, wbm_if.stall, wbs_if.cyc});
        end
    endtask

    task automatic test_reset();
        wbm_if.cyc = 0; wbm_if.stb = 0; wbm_if.we = 0;
        wbm_if.adr = '0; wbm_if.dat_m = '0; wbm_if.sel = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({wbs_if.cyc, wbs_if.stb, wbs_if.we, wbs_if.adr, wbs_if.dat_m, wbs_if.sel,
             wbm_if.ack, wbm_if.err, wbm_if.dat_s, wbm_if.stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: wbs cyc/stb/we=%b%b%b adr=%h wbm ack/err/stall=%b%b%b dat_s=%h, want all 0",
                     wbs_if.cyc, wbs_if.stb, wbs_if.we, wbs_if.adr, wbm_if.ack, wbm_if.err,
                     wbm_if.stall, wbm_if.dat_s);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int unsigned w, t;
        run_txn(32'h1000_0010, 32'hCAFE_F00D, 4'hF, 1'b1, 0, 1, 0, 32'h0BAD_BEEF, w, t);
        finish_txn();
    endtask

    task automatic test_read_stall();
        int unsigned w, t;
        run_txn(32'h2000_0040, 32'h0, 4'hF, 1'b0, 3, 1, 0, 32'h1234_5678, w, t);
        finish_txn();
    endtask

    task automatic test_error();
        int unsigned w, t;
        run_txn(32'h3000_0000, 32'h0, 4'hF, 1'b0, 0, 1, 1, 32'hDEAD_0001, w, t);
        finish_txn();
        run_txn(32'h3000_0004, 32'h0, 4'h3, 1'b0, 1, 2, 2, 32'hDEAD_0002, w, t);
        finish_txn();
    endtask

    task automatic test_back_to_back();
        int unsigned w1, t1, w2, t2;
        run_txn(32'h0, 32'h1111_1111, 4'hF, 1'b1, 0, 1, 0, 32'hA1A1_A1A1, w1, t1);
        run_txn(32'h4, 32'h2222_2222, 4'hF, 1'b1, 0, 1, 0, 32'hB2B2_B2B2, w2, t2);
        finish_txn();
        n_cmp++;
        if (w2 != 1 || t2 - t1 != 4) begin
            n_fail++;
            $display("FAIL b2b_spacing: stalled %0d ack gap %0d, want 1 and 4", w2, t2 - t1);
        end
    endtask

    task automatic test_abort_wait();
        int unsigned w, t, pulses;
        logic ok;
        cfg_stall = 0; cfg_delay = 6; cfg_kind = 0; cfg_data = 32'h7777_7777;
        issue(32'h5000_0000, 32'h0, 4'hF, 1'b0, w, ok);
        @(negedge clk);
        n_cmp++;
        if ({wbs_if.cyc, wbs_if.stb} !== 2'b10) begin
            n_fail++;
            $display("FAIL wait_state: wbs cyc/stb=%b, want 10", {wbs_if.cyc, wbs_if.stb});
        end
        wbm_if.cyc = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wbs_if.cyc, wbs_if.stb, wbm_if.stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_wait: wbs cyc/stb, stall=%b, want 000", {wbs_if.cyc, wbs_if.stb, wbm_if.stall});
        end
        pulses = 0;
        repeat (8) begin
            if (wbm_if.ack === 1'b1 || wbm_if.err === 1'b1) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses != 0 || seen_q.size() != 1) begin
            n_fail++;
            $display("FAIL abort_resp: %0d wbm responses, %0d slave requests, want 0 and 1", pulses, seen_q.size());
        end
        seen_q.delete();
        run_txn(32'h5000_0008, 32'h0, 4'hF, 1'b0, 0, 1, 0, 32'h8888_8888, w, t);
        finish_txn();
    endtask

    task automatic test_abort_req();
        int unsigned w, pulses;
        logic ok;
        cfg_stall = 30; cfg_delay = 1; cfg_kind = 0;
        issue(32'h6000_0000, 32'h6, 4'h1, 1'b1, w, ok);
        wbm_if.cyc = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wbs_if.cyc, wbs_if.stb} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_req: wbs cyc/stb=%b, want 00", {wbs_if.cyc, wbs_if.stb});
        end
        pulses = 0;
        repeat (3) begin
            if (wbm_if.ack === 1'b1 || wbm_if.err === 1'b1) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses != 0 || seen_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_req_resp: %0d responses, %0d slave requests, want 0 and 0", pulses, seen_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int unsigned w, t;
        logic ok;
        cfg_stall = 30; cfg_delay = 1; cfg_kind = 0;
        issue(32'h7000_00F0, 32'h5555_AAAA, 4'hC, 1'b1, w, ok);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({wbs_if.cyc, wbs_if.stb, wbs_if.we, wbs_if.adr, wbs_if.dat_m, wbs_if.sel,
             wbm_if.ack, wbm_if.err, wbm_if.dat_s, wbm_if.stall} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: wbs cyc/stb/we=%b%b%b adr=%h dat=%h wbm stall=%b dat_s=%h, want all 0",
                     wbs_if.cyc, wbs_if.stb, wbs_if.we, wbs_if.adr, wbs_if.dat_m, wbm_if.stall, wbm_if.dat_s);
        end
        @(negedge clk);
        wbm_if.cyc = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (seen_q.size() != 0 || {wbm_if.ack, wbm_if.err, wbm_if.stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset: %0d slave requests ack/err/stall=%b, want 0 and 000",
                     seen_q.size(), {wbm_if.ack, wbm_if.err, wbm_if.stall});
        end
        run_txn(32'h7000_0100, 32'h0, 4'hF, 1'b0, 0, 1, 0, 32'h5A5A_A5A5, w, t);
        finish_txn();
    endtask

    task automatic test_random();
        int unsigned w, t, prev_t, st, dl, kind;
        logic open, b2b;
        open = 1'b0;
        prev_t = 0;
        for (int i = 0; i < 24; i++) begin
            st   = $urandom_range(0, 3);
            dl   = $urandom_range(0, 3);
            kind = $urandom_range(0, 2);
            b2b  = open && ($urandom_range(0, 1) == 1);
            if (open && !b2b) begin
                finish_txn();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            run_txn($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    st, dl, kind, $urandom, w, t);
            n_cmp++;
            if (w != (b2b ? 1 : 0) || (b2b && t - prev_t != 3 + st + dl)) begin
                n_fail++;
                $display("FAIL rand_stall: txn %0d stalled %0d gap %0d, want %0d and %0d",
                         i, w, t - prev_t, b2b ? 1 : 0, 3 + st + dl);
            end
            prev_t = t;
            open = 1'b1;
        end
        finish_txn();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_error();
        test_back_to_back();
        test_abort_wait();
        test_abort_req();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule
